online_mult_sequencer: RTL and testbench

Digit-serial scheduler for the online (MSD-first) multiplier datapath. It sequences one N-digit multiplication through the carry-hold adder stage and the selection logic:
- clears the fractional carry registers;
- steps input digits in during the online-delay warm-up;
- streams N output digits, with zero digits fed in during the drain phase;
- supports stall (hold) and abort.

It sits between the operand digit source and the multiplier core, and it drives the core's add-enable and datapath clock-enable.

---
 rtl/online_mult_sequencer.sv | 163 ++++++++++++++++
 tb/tb_online_mult_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/online_mult_sequencer.sv
// online_mult_sequencer: digit-serial scheduler for the MSD-first online multiplier.
// It moves one N-digit product through four phases. INIT clears the carries. LOAD is
// the online-delay warm-up. RUN takes operand digits and emits result digits. DRAIN
// emits results while zero digits are fed in. Stall and cancel are supported.
module online_mult_sequencer #(
    parameter int N     = 16,
    parameter int DELTA = 3,
    parameter int IW    = $clog2(N + DELTA),
    parameter int OW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          hold,
    input  logic          abort,
    output logic          ready,
    output logic          busy,
    output logic          add_enable,
    output logic          dp_en,
    output logic          in_take,
    output logic          in_zero,
    output logic [IW-1:0] digit_idx,
    output logic          out_valid,
    output logic [OW-1:0] out_idx,
    output logic          out_last,
    output logic          done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [IW-1:0] LOAD_END = IW'(DELTA - 1);
    localparam logic [IW-1:0] RUN_END  = IW'(N - 1);
    localparam logic [IW-1:0] DIG_MAX  = IW'(N + DELTA - 1);
    localparam logic [OW-1:0] OUT_MAX  = OW'(N - 1);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] dig_q;
    logic [IW-1:0] dig_nxt;
    logic [OW-1:0] oidx_q;
    logic [OW-1:0] oidx_nxt;
    logic          ready_q;
    logic          busy_q;
    logic          add_en_q;
    logic          dp_en_q;
    logic          take_q;
    logic          zero_q;
    logic          valid_q;
    logic          last_q;
    logic          done_q;
    logic          stall;

    // Counters saturate instead of wrapping so a stray extra step can never alias index 0.
    function automatic logic [IW-1:0] dig_inc(input logic [IW-1:0] v);
        return (v == DIG_MAX) ? v : v + IW'(1);
    endfunction

    function automatic logic [OW-1:0] oidx_inc(input logic [OW-1:0] v);
        return (v == OUT_MAX) ? v : v + OW'(1);
    endfunction

    // add_en_q is high exactly in LOAD/RUN/DRAIN, the only states where hold is honoured.
    assign stall = hold & add_en_q;

    // Next-state and counter-advance decode: abort beats hold, and hold beats advance.
    always_comb begin
        state_nxt = state;
        dig_nxt   = dig_q;
        oidx_nxt  = oidx_q;
        if (abort) begin
            state_nxt = S_IDLE;
            dig_nxt   = '0;
            oidx_nxt  = '0;
        end else if (!stall) begin
            case (state)
                S_IDLE: begin
                    if (start) state_nxt = S_INIT;
                end
                S_INIT: begin
                    dig_nxt   = '0;
                    oidx_nxt  = '0;
                    state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    dig_nxt = dig_inc(dig_q);
                    if (dig_q == LOAD_END) state_nxt = S_RUN;
                end
                S_RUN: begin
                    dig_nxt  = dig_inc(dig_q);
                    oidx_nxt = oidx_inc(oidx_q);
                    if (dig_q == RUN_END) state_nxt = S_DRAIN;
                end
                S_DRAIN: begin
                    dig_nxt = dig_inc(dig_q);
                    if (oidx_q == OUT_MAX) state_nxt = S_DONE;
                    else                   oidx_nxt  = oidx_inc(oidx_q);
                end
                S_DONE: begin
                    dig_nxt   = '0;
                    oidx_nxt  = '0;
                    state_nxt = S_IDLE;
                end
                default: begin
                    dig_nxt   = '0;
                    oidx_nxt  = '0;
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, counters and phase flags, all registered from the next state so outputs are Moore.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            dig_q    <= '0;
            oidx_q   <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            add_en_q <= 1'b0;
            dp_en_q  <= 1'b0;
            take_q   <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            dig_q    <= dig_nxt;
            oidx_q   <= oidx_nxt;
            ready_q  <= (state_nxt == S_IDLE);
            busy_q   <= (state_nxt != S_IDLE);
            add_en_q <= (state_nxt == S_LOAD) || (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            dp_en_q  <= (state_nxt == S_INIT) || (state_nxt == S_LOAD) ||
                        (state_nxt == S_RUN)  || (state_nxt == S_DRAIN);
            take_q   <= (state_nxt == S_LOAD) || (state_nxt == S_RUN);
            zero_q   <= (state_nxt == S_DRAIN);
            valid_q  <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            last_q   <= (state_nxt == S_DRAIN) && (oidx_nxt == OUT_MAX);
            done_q   <= (state_nxt == S_DONE);
        end
    end

    // During a stall the datapath freezes, but add_enable stays high so the carries survive.
    assign ready      = ready_q;
    assign busy       = busy_q;
    assign add_enable = add_en_q;
    assign dp_en      = dp_en_q & ~stall;
    assign in_take    = take_q  & ~stall;
    assign in_zero    = zero_q  & ~stall;
    assign out_valid  = valid_q & ~stall;
    assign out_last   = last_q  & ~stall;
    assign done       = done_q;
    assign digit_idx  = dig_q;
    assign out_idx    = oidx_q;

endmodule

// File: tb/tb_online_mult_sequencer.sv
// Directed bench for online_mult_sequencer. It runs the nominal, hold, abort, reset,
// busy-start, back-to-back and short-operand (N=4) cases. A queue scoreboard holds the
// expected result-digit order.
module tb_online_mult_sequencer;
    localparam int N   = 8;
    localparam int D   = 3;
    localparam int NB  = 4;
    localparam int IWA = $clog2(N + D);
    localparam int OWA = $clog2(N);
    localparam int IWB = $clog2(NB + D);
    localparam int OWB = $clog2(NB);

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic a_start = 1'b0, a_hold = 1'b0, a_abort = 1'b0;
    logic a_ready, a_busy, a_add_enable, a_dp_en, a_in_take, a_in_zero;
    logic a_out_valid, a_out_last, a_done;
    logic [IWA-1:0] a_digit_idx;
    logic [OWA-1:0] a_out_idx;

    logic b_start = 1'b0, b_hold = 1'b0, b_abort = 1'b0;
    logic b_ready, b_busy, b_add_enable, b_dp_en, b_in_take, b_in_zero;
    logic b_out_valid, b_out_last, b_done;
    logic [IWB-1:0] b_digit_idx;
    logic [OWB-1:0] b_out_idx;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int qa[$];
    int qb[$];
    int a_take = 0, a_val = 0;
    int b_take = 0, b_val = 0, b_zero = 0;

    online_mult_sequencer #(.N(N), .DELTA(D)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .hold(a_hold), .abort(a_abort),
        .ready(a_ready), .busy(a_busy), .add_enable(a_add_enable), .dp_en(a_dp_en),
        .in_take(a_in_take), .in_zero(a_in_zero), .digit_idx(a_digit_idx),
        .out_valid(a_out_valid), .out_idx(a_out_idx), .out_last(a_out_last), .done(a_done)
    );

    online_mult_sequencer #(.N(NB), .DELTA(D)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .hold(b_hold), .abort(b_abort),
        .ready(b_ready), .busy(b_busy), .add_enable(b_add_enable), .dp_en(b_dp_en),
        .in_take(b_in_take), .in_zero(b_in_zero), .digit_idx(b_digit_idx),
        .out_valid(b_out_valid), .out_idx(b_out_idx), .out_last(b_out_last), .done(b_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; the next cycle's inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, then pop the scoreboard on each valid result digit.
    task automatic settle();
        int e;
        #2;
        a_take += int'(a_in_take);
        a_val  += int'(a_out_valid);
        b_take += int'(b_in_take);
        b_val  += int'(b_out_valid);
        b_zero += int'(b_in_zero);
        if (a_out_valid === 1'b1) begin
            chk("a_sb_nonempty", 32'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_out_idx", a_out_idx, e);
                chk("a_out_last", a_out_last, e == N - 1);
            end
        end
        if (b_out_valid === 1'b1) begin
            chk("b_sb_nonempty", 32'(qb.size() != 0), 1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_out_idx", b_out_idx, e);
                chk("b_out_last", b_out_last, e == NB - 1);
            end
        end
    endtask

    // Expected {ready,busy,add_enable,dp_en,in_take,in_zero,out_valid,out_last,done}
    // for active cycle a after the start edge (a<=0 means idle).
    function automatic logic [8:0] exp_vec(input int a, input int nn, input int dd);
        logic [8:0] v;
        v[8] = (a <= 0) || (a >= nn + dd + 3);
        v[7] = (a >= 1) && (a <= nn + dd + 2);
        v[6] = (a >= 2) && (a <= nn + dd + 1);
        v[5] = (a >= 1) && (a <= nn + dd + 1);
        v[4] = (a >= 2) && (a <= nn + 1);
        v[3] = (a >= nn + 2) && (a <= nn + dd + 1);
        v[2] = (a >= dd + 2) && (a <= nn + dd + 1);
        v[1] = (a == nn + dd + 1);
        v[0] = (a == nn + dd + 2);
        return v;
    endfunction

    function automatic logic [8:0] obs_a();
        return {a_ready, a_busy, a_add_enable, a_dp_en, a_in_take, a_in_zero,
                a_out_valid, a_out_last, a_done};
    endfunction

    task automatic push_a();
        for (int i = 0; i < N; i++) qa.push_back(i);
    endtask

    // One operation on dut_a: hold window [hs, hs+hl), optional abort cycle, optional
    // start pulse while busy, pre = start already sampled, chain = start again when ready.
    task automatic op_a(input int hs, input int hl, input int abort_at, input int busy_start,
                        input bit pre, input bit chain);
        int last_k;
        int hb;
        int a;
        bit inh;
        if (!pre) begin
            a_start = 1'b1;
            push_a();
            settle();
            tick();
        end
        a_start = 1'b0;
        a_take  = 0;
        a_val   = 0;
        last_k  = N + D + 3 + hl;
        for (int k = 1; k <= last_k; k++) begin
            a_start = (k == busy_start);
            a_hold  = (k >= hs) && (k < hs + hl);
            a_abort = (k == abort_at);
            inh     = a_hold;
            hb      = (k < hs) ? 0 : (((k - hs) < hl) ? (k - hs) : hl);
            a       = k - hb;
            if (k == last_k) begin
                chk("a_sb_drained", qa.size(), 0);
                chk("a_total_in_take", a_take, N);
                chk("a_total_out_valid", a_val, N);
                if (chain) begin
                    a_start = 1'b1;
                    push_a();
                end
            end
            settle();
            if (inh) begin
                chk($sformatf("a_hold_outputs_c%0d", k), obs_a(), 9'b011000000);
                chk("a_hold_out_idx", a_out_idx, hs - D - 2);
                chk("a_hold_digit_idx", a_digit_idx, hs - 2);
            end else begin
                chk($sformatf("a_outputs_c%0d", k), obs_a(), exp_vec(a, N, D));
                if (a != N + D + 2)
                    chk($sformatf("a_digit_idx_c%0d", k), a_digit_idx,
                        ((a >= 2) && (a <= N + D + 1)) ? a - 2 : 0);
            end
            tick();
            if (k == abort_at) begin
                a_abort = 1'b0;
                a_hold  = 1'b0;
                qa.delete();
                a_start = chain;
                if (chain) push_a();
                settle();
                chk("a_abort_idle", obs_a(), exp_vec(0, N, D));
                chk("a_abort_digit_idx", a_digit_idx, 0);
                chk("a_abort_out_idx", a_out_idx, 0);
                tick();
                a_start = 1'b0;
                return;
            end
        end
        a_start = 1'b0;
        a_hold  = 1'b0;
    endtask

    initial begin
        int done_k;
        int run_cycles;

        // Reset values on both instances.
        tick();
        tick();
        settle();
        chk("reset_outputs", obs_a(), exp_vec(0, N, D));
        chk("reset_digit_idx", a_digit_idx, 0);
        chk("reset_out_idx", a_out_idx, 0);
        chk("b_reset_ready", b_ready, 1);
        reset_n = 1'b1;
        tick();

        // Nominal with a start pulse while busy at cycle 3, then back-to-back start.
        op_a(99, 0, -1, 3, 1'b0, 1'b1);
        // Second operation (already started): 2-cycle hold at cycle 6, done slips to 15.
        op_a(6, 2, -1, -1, 1'b1, 1'b0);
        // Abort in RUN at cycle 7, new start in the idle cycle that follows.
        op_a(99, 0, 7, -1, 1'b0, 1'b1);
        op_a(99, 0, -1, -1, 1'b1, 1'b0);

        // Reset during LOAD at cycle 4, with start asserted alongside it.
        a_start = 1'b1;
        push_a();
        settle();
        tick();
        a_start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            settle();
            chk($sformatf("rst_pre_c%0d", k), obs_a(), exp_vec(k, N, D));
            tick();
        end
        reset_n = 1'b0;
        a_start = 1'b1;
        settle();
        chk("rst_c4_still_load", obs_a(), exp_vec(4, N, D));
        tick();
        reset_n = 1'b1;
        a_start = 1'b0;
        qa.delete();
        settle();
        chk("rst_c5_outputs", obs_a(), exp_vec(0, N, D));
        chk("rst_c5_digit_idx", a_digit_idx, 0);
        chk("rst_c5_out_idx", a_out_idx, 0);
        tick();
        settle();
        chk("rst_c6_start_dropped", obs_a(), exp_vec(0, N, D));
        tick();

        // Short operand N=4, DELTA=3: RUN is a single cycle.
        b_start = 1'b1;
        for (int i = 0; i < NB; i++) qb.push_back(i);
        settle();
        tick();
        b_start = 1'b0;
        b_take = 0;
        b_val = 0;
        b_zero = 0;
        done_k = -1;
        run_cycles = 0;
        for (int k = 1; k <= NB + D + 4; k++) begin
            settle();
            if (b_done === 1'b1 && done_k < 0) done_k = k;
            if (b_in_take === 1'b1 && b_out_valid === 1'b1) run_cycles++;
            tick();
        end
        chk("b_total_in_take", b_take, NB);
        chk("b_total_out_valid", b_val, NB);
        chk("b_total_in_zero", b_zero, D);
        chk("b_run_cycles", run_cycles, 1);
        chk("b_done_cycle", done_k, NB + D + 2);
        chk("b_sb_drained", qb.size(), 0);
        settle();
        chk("b_final_idle", {b_ready, b_busy, b_add_enable, b_dp_en}, 4'b1000);
        chk("b_final_digit_idx", b_digit_idx, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
